// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: FSM states, instruction sizes and alignment mask shared by pc_gen (honours PC_GEN_RVC_EN)
package pc_gen_pkg;
  typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;
  localparam int INSN_BYTES = 4;
  localparam int INSN_BYTES_C = 2;
  // Low PC bits that must be zero for a legal fetch target
  function automatic logic [1:0] low_mask();
`ifdef PC_GEN_RVC_EN
    return 2'b01;
`else
    return 2'b11;
`endif
  endfunction
endpackage

// File: rtl/pc_align_chk.sv
// pc_align_chk: forces a fetch target onto an instruction boundary and flags when it had to
module pc_align_chk
  import pc_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] aligned,
  output logic            bad
);
  assign bad = |(target[1:0] & low_mask());
  assign aligned = {target[XLEN-1:2], target[1:0] & ~low_mask()};
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator, trap > redirect > sequential, with stall-time target latching (PC_GEN_RVC_EN adds 2-byte steps)
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  output logic            fetch_valid,
  input  logic            fetch_ready,
`ifdef PC_GEN_RVC_EN
  input  logic            fetch_is_c,
`endif
  output logic [XLEN-1:0] fetch_pc,
  output logic [XLEN-1:0] npc_seq,
  output logic            misalign_err
);
  state_t state_q, state_d;
  logic [XLEN-1:0] pend_q, raw_tgt, tgt;
  logic accept, load, bad, latch;
  assign fetch_valid = state_q != BOOT;
  assign accept = en && fetch_valid && fetch_ready;
`ifdef PC_GEN_RVC_EN
  assign npc_seq = fetch_pc + (fetch_is_c ? XLEN'(INSN_BYTES_C) : XLEN'(INSN_BYTES));
`else
  assign npc_seq = fetch_pc + XLEN'(INSN_BYTES);
`endif
  // A latched target is older than any new redirect, so only a trap can displace it
  assign raw_tgt = trap_valid ? trap_vector : (state_q == PEND) ? pend_q : redirect_target;
  assign load = trap_valid || redirect_valid || state_q == PEND;
  assign latch = en && fetch_valid && !accept && (trap_valid || (redirect_valid && state_q == RUN));
  pc_align_chk #(.XLEN(XLEN)) u_align (
    .target (raw_tgt),
    .aligned(tgt),
    .bad    (bad)
  );
  // Next state: leave BOOT once enabled, park in PEND while a target waits for acceptance
  always_comb begin
    state_d = !en ? state_q : (state_q == BOOT || accept) ? RUN : load ? PEND : state_q;
  end
  // State, PC, pending target and the one-cycle misalignment pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= BOOT;
      fetch_pc     <= RESET_VECTOR;
      pend_q       <= '0;
      misalign_err <= 1'b0;
    end else begin
      state_q      <= state_d;
      misalign_err <= accept && load && bad;
      if (accept) fetch_pc <= load ? tgt : npc_seq;
      if (latch) pend_q <= raw_tgt;
    end
  end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scoreboard bench for pc_gen; expected fetches are queued by stimulus, popped by a monitor
module tb_pc_gen;
  typedef struct {
    logic [31:0] pc;
    logic        err;
  } exp_t;
  logic clk = 1'b0;
  logic rst, en, redirect_valid, trap_valid, fetch_ready, fetch_valid, misalign_err;
  logic [31:0] redirect_target, trap_vector, fetch_pc, npc_seq;
`ifdef PC_GEN_RVC_EN
  logic fetch_is_c = 1'b0;
`endif
  exp_t q[$];
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .trap_valid     (trap_valid),
    .trap_vector    (trap_vector),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
`ifdef PC_GEN_RVC_EN
    .fetch_is_c     (fetch_is_c),
`endif
    .fetch_pc       (fetch_pc),
    .npc_seq        (npc_seq),
    .misalign_err   (misalign_err)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // One clock of stimulus; when a fetch is expected to be accepted, queue what it must look like
  task automatic step(input logic e, input logic r, input logic rv, input logic [31:0] rt,
                      input logic tv, input logic [31:0] tvec,
                      input bit acc, input logic [31:0] epc, input logic eerr);
    en = e;
    fetch_ready = r;
    redirect_valid = rv;
    redirect_target = rt;
    trap_valid = tv;
    trap_vector = tvec;
    if (acc) q.push_back('{pc: epc, err: eerr});
    @(posedge clk);
    #1;
  endtask
  // Monitor: every accepted fetch must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst && en && fetch_valid && fetch_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fetch: got pc %h expected no fetch", fetch_pc);
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("fetch_pc", fetch_pc, x.pc);
        chk("misalign_err", {31'b0, misalign_err}, {31'b0, x.err});
      end
    end
  end
  initial begin
    rst = 1'b0;
    en = 1'b0;
    fetch_ready = 1'b0;
    redirect_valid = 1'b0;
    trap_valid = 1'b0;
    redirect_target = '0;
    trap_vector = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fetch_valid", {31'b0, fetch_valid}, 32'h0);
    chk("rst_fetch_pc", fetch_pc, 32'h0);
    chk("rst_misalign_err", {31'b0, misalign_err}, 32'h0);
    rst = 1'b1;
    chk("boot_fetch_valid", {31'b0, fetch_valid}, 32'h0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("run_fetch_valid", {31'b0, fetch_valid}, 32'h1);
    chk("npc_seq", npc_seq, 32'h4);
    step(1, 1, 0, 0, 0, 0, 1, 32'h0, 0);
    step(1, 1, 0, 0, 0, 0, 1, 32'h4, 0);
    step(1, 1, 1, 32'h100, 0, 0, 1, 32'h8, 0);
    step(1, 1, 0, 0, 0, 0, 1, 32'h100, 0);
    step(1, 1, 0, 0, 0, 0, 1, 32'h104, 0);
    step(1, 0, 1, 32'h200, 0, 0, 0, 0, 0);
    chk("stall1_pc", fetch_pc, 32'h108);
    step(1, 0, 1, 32'h300, 0, 0, 0, 0, 0);
    chk("stall2_pc", fetch_pc, 32'h108);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("stall3_pc", fetch_pc, 32'h108);
    step(1, 1, 0, 0, 0, 0, 1, 32'h108, 0);
    step(1, 1, 0, 0, 0, 0, 1, 32'h200, 0);
    step(1, 1, 0, 0, 0, 0, 1, 32'h204, 0);
    step(1, 1, 1, 32'h400, 1, 32'h80, 1, 32'h208, 0);
    step(1, 1, 0, 0, 0, 0, 1, 32'h80, 0);
    step(1, 1, 0, 0, 0, 0, 1, 32'h84, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, i[0] == 1'b0, 32'h500, 0, 0, 0, 0, 0);
      chk("en0_pc", fetch_pc, 32'h88);
      chk("en0_valid", {31'b0, fetch_valid}, 32'h1);
    end
    step(1, 1, 0, 0, 0, 0, 1, 32'h88, 0);
    step(1, 1, 1, 32'h102, 0, 0, 1, 32'h8c, 0);
`ifdef PC_GEN_RVC_EN
    step(1, 1, 0, 0, 0, 0, 1, 32'h102, 0);
    step(1, 1, 1, 32'hffff_fffc, 0, 0, 1, 32'h106, 0);
`else
    step(1, 1, 0, 0, 0, 0, 1, 32'h100, 1);
    step(1, 1, 1, 32'hffff_fffc, 0, 0, 1, 32'h104, 0);
`endif
    step(1, 1, 0, 0, 0, 0, 1, 32'hffff_fffc, 0);
    step(1, 1, 0, 0, 0, 0, 1, 32'h0, 0);
    step(1, 0, 1, 32'h700, 0, 0, 0, 0, 0);
    chk("pre_reset_pc", fetch_pc, 32'h4);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, fetch_valid}, 32'h0);
    chk("async_rst_pc", fetch_pc, 32'h0);
    chk("queue_drained", q.size(), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 1, 32'h0, 0);
    step(1, 1, 0, 0, 0, 0, 1, 32'h4, 0);
    chk("final_queue_drained", q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
